mem_slave: RTL
==============

# mem_slave

Parametrised single-port memory target that executes write and read requests from a memory-agent driver and returns read data through a buffered response channel. It generalises the fixed 2-bit-address / 8-bit-data memory interface to configurable address width, data width and depth. It adds valid/ready flow control on both channels, a 2-entry response FIFO and out-of-range error reporting. It sits behind the mem agent in the training bench as the device under test.

## Interface
- `AW`, default 2: address width in bits.
- `DW`, default 8: data width in bits.
- `DEPTH`, default 4: number of implemented words. Must be in the range 1..2**AW.
- `clk`  in  1: single clock. All logic is on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `req_valid`  in  1: a request is present.
- `req_ready`  out  1: the block can accept a request.
- `req_write`  in  1: 1 = write, 0 = read.
- `req_addr`  in  AW: word address.
- `req_wdata`  in  DW: write data. Ignored for reads.
- `rsp_valid`  out  1: read response is present.
- `rsp_ready`  in  1: the consumer accepts the response.
- `rsp_rdata`  out  DW: read data.
- `rsp_err`  out  1: the response is erroneous (out-of-range address, or parity failure when parity is enabled).

## Operation
- **Handshake.** A request is accepted on a rising edge with `req_valid && req_ready`. A response is consumed on a rising edge with `rsp_valid && rsp_ready`.
- **Request channel rules.** `req_*` must be held stable while `req_valid && !req_ready`. Once `req_valid` is raised it must not drop before acceptance.
- **req_ready.** `req_ready = (fifo_count < 2)`. It is purely registered-state based and does not depend combinationally on `rsp_ready`. It gates writes as well as reads.
- **Write.** An accepted write with `req_addr < DEPTH` updates the word at that edge. No response is generated. A write with `req_addr >= DEPTH` is silently dropped, with no response and no error.
- **Read.** An accepted read pushes `{err, data}` into the response FIFO at the accept edge.
  - `data = mem[req_addr]` when in range.
  - Out of range: `data = '0` and `err = 1`.
- **Response FIFO.** 2 entries, delivered in order. `rsp_valid = (fifo_count != 0)`. `rsp_rdata` and `rsp_err` show the head entry.
- **Simultaneous events.** Push and pop on the same edge leave `fifo_count` unchanged and preserve order.
- **Read-after-write.** A write accepted at edge N is visible to a read accepted at edge N+1 or later.
- **Reset values.**
  - `req_ready` = 1, `rsp_valid` = 0, `rsp_rdata` = 0, `rsp_err` = 0.
  - `fifo_count` = 0.
  - All storage words = 0.
- **Reset mid-operation.** Asserting reset discards queued responses and clears storage immediately (asynchronously). No response is emitted for a request accepted on the same edge that reset is released.

## Timing
- **Read latency.** Accept at edge N gives `rsp_valid` = 1 after edge N when the FIFO was empty, i.e. the response is visible in cycle N+1.
- **Throughput.** One request per cycle while `rsp_ready` is held at 1.
- **Backpressure.**
  - With `rsp_ready` = 0, at most 2 reads are accepted, then `req_ready` drops.
  - `req_ready` returns to 1 in the cycle after the first pop.
- **Response stability.** `rsp_*` are held stable while `rsp_valid && !rsp_ready`.

## Configuration
- **`MEM_PARITY_EN` defined.**
  - Each stored word carries one even-parity bit, computed on write.
  - A read recomputes parity and sets `err = 1` on mismatch. The data is still returned.
  - A test-only internal force path `parity_flip` (hierarchical force) corrupts one stored parity bit.
- **`MEM_PARITY_EN` undefined.**
  - No parity storage.
  - `rsp_err` is driven only by the out-of-range check.

## Structure
- **Package `mem_pkg`.**
  - `mem_op_e` (MEM_RD, MEM_WR).
  - Struct `mem_rsp_t` with fields `err` and `data`. It is parametrised via the module's `DW` and therefore declared with the maximum width `MEM_MAX_DW` = 64; slicing to `DW` happens locally.
  - Constant `MEM_RSP_FIFO_DEPTH` = 2.
- **Sub-module `mem_rsp_fifo`.**
  - 2-entry FIFO with push, pop, count, full and empty.
  - Asynchronous active-low reset.
  - Instantiated once.
- The storage array and request decode live in `mem_slave`.

## Test plan
- **Reset.** Reset, then idle → `req_ready` = 1 and `rsp_valid` = 0. Reading addresses 0..3 returns 0x00 with `rsp_err` = 0 on each.
- **Write/read back.** Write 0xA5 to addr 2, read addr 2 on the next cycle → `rsp_rdata` = 0xA5 one cycle after the read is accepted, `rsp_err` = 0.
- **Backpressure.**
  - Hold `rsp_ready` = 0 and issue 3 reads (addr 0, 1, 2) → the third stalls with `req_ready` = 0.
  - Release `rsp_ready` → responses arrive in order 0, 1, 2, with no loss.
- **Out of range.** DEPTH = 3, AW = 2: write 0x11 to addr 3, then read addr 3 → `rsp_rdata` = 0, `rsp_err` = 1. Addrs 0..2 are unchanged.
- **Mid-operation reset.** Two responses queued, pulse `rst_n` low for 1 cycle → `rsp_valid` drops immediately, and every address then reads 0.
- **Parity error (`MEM_PARITY_EN`).** Write 0x3C to addr 1, flip its parity bit, read addr 1 → `rsp_rdata` = 0x3C, `rsp_err` = 1.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and constants for the mem_slave memory target and its response FIFO.
package mem_pkg;

    typedef enum logic {
        MEM_RD = 1'b0,
        MEM_WR = 1'b1
    } mem_op_e;

    localparam int unsigned MEM_MAX_DW         = 64;
    localparam int unsigned MEM_RSP_FIFO_DEPTH = 2;
    localparam int unsigned MEM_CNT_W          = $clog2(MEM_RSP_FIFO_DEPTH + 1);

    // Data is carried at full width; each instance slices it down to its own DW.
    typedef struct packed {
        logic                  err;
        logic [MEM_MAX_DW-1:0] data;
    } mem_rsp_t;

endpackage

// File: rtl/mem_rsp_fifo.sv
// Two-entry in-order response FIFO holding {err, data} read responses.
module mem_rsp_fifo
    import mem_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 push_i,
    input  mem_rsp_t             push_data_i,
    input  logic                 pop_i,
    output mem_rsp_t             head_o,
    output logic [MEM_CNT_W-1:0] count_o,
    output logic                 full_o,
    output logic                 empty_o
);

    mem_rsp_t             entry_q [MEM_RSP_FIFO_DEPTH];
    logic                 wr_ptr_q, wr_ptr_d;
    logic                 rd_ptr_q, rd_ptr_d;
    logic [MEM_CNT_W-1:0] count_q, count_d;
    logic                 do_push, do_pop;

    assign full_o  = (count_q == MEM_CNT_W'(MEM_RSP_FIFO_DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = entry_q[rd_ptr_q];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // One-bit pointers wrap naturally for the two entries.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = ~wr_ptr_q;
        end
        if (do_pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + MEM_CNT_W'(1);
            2'b01:   count_d = count_q - MEM_CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= '0;
            for (int i = 0; i < int'(MEM_RSP_FIFO_DEPTH); i++) begin
                entry_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (do_push) begin
                entry_q[wr_ptr_q] <= push_data_i;
            end
        end
    end

endmodule

// File: rtl/mem_slave.sv
// Parametrised single-port memory target with valid/ready request and response channels.
// Optional per-word even parity is enabled by defining MEM_PARITY_EN.
module mem_slave
    import mem_pkg::*;
#(
    parameter int unsigned AW    = 2,
    parameter int unsigned DW    = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_write,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_rdata,
    output logic          rsp_err
);

    localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DW-1:0]        mem_q [DEPTH];
    mem_op_e              op;
    logic                 accept;
    logic                 in_range;
    logic                 wr_en;
    logic                 rd_push;
    logic [IdxW-1:0]      idx;
    logic [DW-1:0]        rd_data;
    logic                 rd_err;
    mem_rsp_t             push_rsp;
    mem_rsp_t             head_rsp;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [MEM_CNT_W-1:0] fifo_count;

    assign op       = mem_op_e'(req_write);
    assign in_range = (32'(req_addr) < DEPTH);
    assign idx      = IdxW'(req_addr);

    // Readiness depends only on FIFO occupancy, never on rsp_ready.
    assign req_ready = !fifo_full;
    assign accept    = req_valid && req_ready;
    assign wr_en     = accept && (op == MEM_WR) && in_range;
    assign rd_push   = accept && (op == MEM_RD);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                if (idx == IdxW'(i)) begin
                    mem_q[i] <= req_wdata;
                end
            end
        end
    end

`ifdef MEM_PARITY_EN
    logic             par_q [DEPTH];
    // Held at zero in silicon; a bench forces bits to corrupt stored parity.
    logic [DEPTH-1:0] parity_flip;
    assign parity_flip = '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                par_q[i] <= 1'b0;
            end
        end else if (wr_en) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                if (idx == IdxW'(i)) begin
                    par_q[i] <= ^req_wdata;
                end
            end
        end
    end
`endif

    always_comb begin
        rd_data = '0;
        rd_err  = 1'b1;
        if (in_range) begin
            rd_data = mem_q[idx];
            rd_err  = 1'b0;
`ifdef MEM_PARITY_EN
            rd_err  = ((^mem_q[idx]) != (par_q[idx] ^ parity_flip[idx]));
`endif
        end
    end

    always_comb begin
        push_rsp      = '0;
        push_rsp.err  = rd_err;
        push_rsp.data = MEM_MAX_DW'(rd_data);
    end

    mem_rsp_fifo u_rsp_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (rd_push),
        .push_data_i (push_rsp),
        .pop_i       (rsp_ready),
        .head_o      (head_rsp),
        .count_o     (fifo_count),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    assign rsp_valid = !fifo_empty;
    assign rsp_rdata = DW'(head_rsp.data);
    assign rsp_err   = head_rsp.err;

    a_count_bounded : assert property (@(posedge clk) disable iff (!rst_n)
        (fifo_count <= MEM_CNT_W'(MEM_RSP_FIFO_DEPTH)) && (fifo_empty == (fifo_count == '0)));

endmodule
